ex_mem_pipe_stage: RTL and testbench

- Parametrised EX->MEM pipeline stage with a valid/ready handshake, flush and an optional 2-entry skid buffer.
- Sits between the ALU/EX stage and the data-memory stage of the RISC-V pipeline.
- Carries ALU result, store data, destination register and MEM/WB control bits.
- Lets the MEM stage stall (out_ready=0) and lets the hazard unit squash in-flight instructions (flush).
- Exposes a registered forwarding tap for the EX-stage bypass mux.

---
 rtl/ex_mem_pipe_stage_pkg.sv | 34 +++
 rtl/pipe_skid_buf.sv | 115 +++++++++++
 rtl/ex_mem_pipe_stage.sv | 95 +++++++++
 tb/tb_ex_mem_pipe_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared EX/MEM pipeline types: control bundle, payload layout and the
// occupancy states used by the pipeline buffers.
package ex_mem_pipe_stage_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int RADDR_W_DEF = 5;
   localparam int CTRL_W      = 4;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
      logic memwrite;
      logic memread;
   } ex_mem_ctrl_t;

   // Control sits in the MSBs so a buffer can clear it by position on flush.
   typedef struct packed {
      ex_mem_ctrl_t             ctrl;
      logic [XLEN_DEF-1:0]      alu_result;
      logic [XLEN_DEF-1:0]      mem_wdata;
      logic [RADDR_W_DEF-1:0]   rd_addr;
   } ex_mem_payload_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   function automatic ex_mem_ctrl_t gate_ctrl(input logic valid, input ex_mem_ctrl_t c);
      return valid ? c : '0;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with flush. SKID=1 gives a two-entry
// buffer whose in_ready is purely registered; SKID=0 is a single entry.
module pipe_skid_buf
   import ex_mem_pipe_stage_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CLR_W = 1,
   parameter int SKID  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // Flush zeroes the top CLR_W bits of every stored entry and keeps the rest.
   localparam logic [WIDTH-1:0] KEEP_MASK = {{CLR_W{1'b0}}, {(WIDTH-CLR_W){1'b1}}};

   logic             main_valid_q;
   logic [WIDTH-1:0] main_data_q;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = main_valid_q & out_ready;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

   generate
      if (SKID != 0) begin : g_skid
         skid_state_e      state_q;
         logic             skid_valid_q;
         logic [WIDTH-1:0] skid_data_q;

         assign in_ready = ~skid_valid_q;

         // NOTE: state updates use non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q      <= ST_EMPTY;
               main_valid_q <= 1'b0;
               skid_valid_q <= 1'b0;
               // NOTE: data registers are reset too, so the stage powers up
               // with all-zero outputs rather than X payloads.
               main_data_q  <= '0;
               skid_data_q  <= '0;
            end else if (flush) begin
               state_q      <= ST_EMPTY;
               main_valid_q <= 1'b0;
               skid_valid_q <= 1'b0;
               main_data_q  <= main_data_q & KEEP_MASK;
               skid_data_q  <= skid_data_q & KEEP_MASK;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (in_xfer) begin
                        main_data_q  <= in_data;
                        main_valid_q <= 1'b1;
                        state_q      <= ST_ONE;
                     end
                  end
                  ST_ONE: begin
                     if (in_xfer && out_xfer) begin
                        main_data_q <= in_data;
                     end else if (out_xfer) begin
                        main_valid_q <= 1'b0;
                        state_q      <= ST_EMPTY;
                     end else if (in_xfer) begin
                        skid_data_q  <= in_data;
                        skid_valid_q <= 1'b1;
                        state_q      <= ST_TWO;
                     end
                  end
                  ST_TWO: begin
                     if (out_xfer) begin
                        main_data_q  <= skid_data_q;
                        skid_valid_q <= 1'b0;
                        state_q      <= ST_ONE;
                     end
                  end
                  default: begin
                     state_q      <= ST_EMPTY;
                     main_valid_q <= 1'b0;
                     skid_valid_q <= 1'b0;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign in_ready = ~main_valid_q | out_ready;

         always_ff @(posedge clk) begin
            if (rst) begin
               main_valid_q <= 1'b0;
               main_data_q  <= '0;
            end else if (flush) begin
               main_valid_q <= 1'b0;
               main_data_q  <= main_data_q & KEEP_MASK;
            end else if (in_xfer) begin
               main_valid_q <= 1'b1;
               main_data_q  <= in_data;
            end else if (out_xfer) begin
               main_valid_q <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: packs the EX bundle into a flushable skid buffer and
// exposes the MEM-side fields plus a forwarding tap for the EX bypass mux.
module ex_mem_pipe_stage
   import ex_mem_pipe_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int SKID    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               memtoreg_ex,
   input  logic               regwrite_ex,
   input  logic               memwrite_ex,
   input  logic               memread_ex,
   input  logic [XLEN-1:0]    alu_result_ex,
   input  logic [XLEN-1:0]    mem_wdata_ex,
   input  logic [RADDR_W-1:0] rd_addr_ex,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               memtoreg_mem,
   output logic               regwrite_mem,
   output logic               memwrite_mem,
   output logic               memread_mem,
   output logic [XLEN-1:0]    alu_result_mem,
   output logic [XLEN-1:0]    mem_wdata_mem,
   output logic [RADDR_W-1:0] rd_addr_mem,
   output logic               fwd_en,
   output logic [RADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]    fwd_data
);

   // Same layout as ex_mem_payload_t, sized by this instance's parameters.
   typedef struct packed {
      ex_mem_ctrl_t       ctrl;
      logic [XLEN-1:0]    alu_result;
      logic [XLEN-1:0]    mem_wdata;
      logic [RADDR_W-1:0] rd_addr;
   } stage_payload_t;

   localparam int PAY_W = $bits(stage_payload_t);

   stage_payload_t pay_in;
   stage_payload_t pay_out;
   logic [PAY_W-1:0] pay_out_raw;
   ex_mem_ctrl_t   ctrl_vis;

   always_comb begin
      pay_in               = '0;
      pay_in.ctrl.memtoreg = memtoreg_ex;
      pay_in.ctrl.regwrite = regwrite_ex;
      pay_in.ctrl.memwrite = memwrite_ex;
      pay_in.ctrl.memread  = memread_ex;
      pay_in.alu_result    = alu_result_ex;
      pay_in.mem_wdata     = mem_wdata_ex;
      pay_in.rd_addr       = rd_addr_ex;
   end

   pipe_skid_buf #(
      .WIDTH (PAY_W),
      .CLR_W (CTRL_W),
      .SKID  (SKID)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out_raw)
   );

   assign pay_out = stage_payload_t'(pay_out_raw);

   // A drained entry keeps its stored control bits, so gate them with valid.
   assign ctrl_vis       = gate_ctrl(out_valid, pay_out.ctrl);
   assign memtoreg_mem   = ctrl_vis.memtoreg;
   assign regwrite_mem   = ctrl_vis.regwrite;
   assign memwrite_mem   = ctrl_vis.memwrite;
   assign memread_mem    = ctrl_vis.memread;
   assign alu_result_mem = pay_out.alu_result;
   assign mem_wdata_mem  = pay_out.mem_wdata;
   assign rd_addr_mem    = pay_out.rd_addr;

   // Loads are excluded: their result is only known after the memory access.
   assign fwd_en   = out_valid & regwrite_mem & ~memread_mem & (rd_addr_mem != '0);
   assign fwd_rd   = rd_addr_mem;
   assign fwd_data = alu_result_mem;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: a SKID=1 instance driven through
// directed vectors and a SKID=0 instance for the combinational-ready case.
module tb_ex_mem_pipe_stage;
   import ex_mem_pipe_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // SKID=1 instance
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic        memtoreg_ex, regwrite_ex, memwrite_ex, memread_ex;
   logic [31:0] alu_result_ex, mem_wdata_ex;
   logic [4:0]  rd_addr_ex;
   logic        memtoreg_mem, regwrite_mem, memwrite_mem, memread_mem;
   logic [31:0] alu_result_mem, mem_wdata_mem;
   logic [4:0]  rd_addr_mem;
   logic        fwd_en;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   // SKID=0 instance
   logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
   logic        s0_memtoreg_ex, s0_regwrite_ex, s0_memwrite_ex, s0_memread_ex;
   logic [31:0] s0_alu_result_ex, s0_mem_wdata_ex;
   logic [4:0]  s0_rd_addr_ex;
   logic        s0_memtoreg_mem, s0_regwrite_mem, s0_memwrite_mem, s0_memread_mem;
   logic [31:0] s0_alu_result_mem, s0_mem_wdata_mem;
   logic [4:0]  s0_rd_addr_mem;
   logic        s0_fwd_en;
   logic [4:0]  s0_fwd_rd;
   logic [31:0] s0_fwd_data;

   ex_mem_pipe_stage #(.XLEN(32), .RADDR_W(5), .SKID(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
      .memwrite_ex(memwrite_ex), .memread_ex(memread_ex),
      .alu_result_ex(alu_result_ex), .mem_wdata_ex(mem_wdata_ex), .rd_addr_ex(rd_addr_ex),
      .out_valid(out_valid), .out_ready(out_ready),
      .memtoreg_mem(memtoreg_mem), .regwrite_mem(regwrite_mem),
      .memwrite_mem(memwrite_mem), .memread_mem(memread_mem),
      .alu_result_mem(alu_result_mem), .mem_wdata_mem(mem_wdata_mem), .rd_addr_mem(rd_addr_mem),
      .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   ex_mem_pipe_stage #(.XLEN(32), .RADDR_W(5), .SKID(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(s0_flush),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready),
      .memtoreg_ex(s0_memtoreg_ex), .regwrite_ex(s0_regwrite_ex),
      .memwrite_ex(s0_memwrite_ex), .memread_ex(s0_memread_ex),
      .alu_result_ex(s0_alu_result_ex), .mem_wdata_ex(s0_mem_wdata_ex), .rd_addr_ex(s0_rd_addr_ex),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready),
      .memtoreg_mem(s0_memtoreg_mem), .regwrite_mem(s0_regwrite_mem),
      .memwrite_mem(s0_memwrite_mem), .memread_mem(s0_memread_mem),
      .alu_result_mem(s0_alu_result_mem), .mem_wdata_mem(s0_mem_wdata_mem), .rd_addr_mem(s0_rd_addr_mem),
      .fwd_en(s0_fwd_en), .fwd_rd(s0_fwd_rd), .fwd_data(s0_fwd_data)
   );

   int n_tests = 0;
   int n_fail  = 0;
   ex_mem_payload_t exp_q[$];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ctrl order: {memtoreg, regwrite, memwrite, memread}
   function automatic ex_mem_payload_t mk(input logic [31:0] alu, input logic [31:0] wd,
                                          input logic [4:0] rd, input logic [3:0] c);
      ex_mem_payload_t p;
      p.ctrl       = ex_mem_ctrl_t'(c);
      p.alu_result = alu;
      p.mem_wdata  = wd;
      p.rd_addr    = rd;
      return p;
   endfunction

   task automatic drive(input ex_mem_payload_t p);
      {memtoreg_ex, regwrite_ex, memwrite_ex, memread_ex} = p.ctrl;
      alu_result_ex = p.alu_result;
      mem_wdata_ex  = p.mem_wdata;
      rd_addr_ex    = p.rd_addr;
   endtask

   // Holds in_valid until the stage accepts, then returns #1 after that edge.
   task automatic send(input ex_mem_payload_t p, input bit expect_out);
      bit accepted = 1'b0;
      drive(p);
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (expect_out) exp_q.push_back(p);
            accepted = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!accepted) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck low for alu 0x%0h", p.alu_result);
      end
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   // Monitor: every output transfer must match the head of the scoreboard.
   initial begin
      ex_mem_payload_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: got alu 0x%0h with empty scoreboard", alu_result_mem);
            end else begin
               e = exp_q.pop_front();
               check("out_data", {alu_result_mem, mem_wdata_mem}, {e.alu_result, e.mem_wdata});
               check("out_ctrl_rd", {memtoreg_mem, regwrite_mem, memwrite_mem, memread_mem, rd_addr_mem},
                     {e.ctrl, e.rd_addr});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(mk(32'h0, 32'h0, 5'd0, 4'b0000));
      s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0;
      {s0_memtoreg_ex, s0_regwrite_ex, s0_memwrite_ex, s0_memread_ex} = 4'b0000;
      s0_alu_result_ex = '0; s0_mem_wdata_ex = '0; s0_rd_addr_ex = '0;

      // Reset state
      cycle(); cycle();
      check("rst_in_ready_skid", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {memtoreg_mem, regwrite_mem, memwrite_mem, memread_mem,
                            alu_result_mem, mem_wdata_mem, rd_addr_mem}, 0);
      check("rst_fwd_en", fwd_en, 0);
      rst = 1'b0;
      cycle();
      check("post_rst_in_ready", in_ready, 1);

      // Pass-through with out_ready held high
      out_ready = 1'b1;
      send(mk(32'h10, 32'h0, 5'd5, 4'b0100), 1);
      check("pt_out_valid", out_valid, 1);
      check("pt_alu", alu_result_mem, 32'h10);
      check("pt_rd", rd_addr_mem, 5);
      check("pt_fwd", {fwd_en, fwd_rd, fwd_data}, {1'b1, 5'd5, 32'h10});
      wait_empty("pt_drain");

      // Back-pressure: A, B fill both entries, C waits at the input
      out_ready = 1'b0;
      send(mk(32'h11, 32'hA1, 5'd1, 4'b0100), 1);
      send(mk(32'h22, 32'hB2, 5'd2, 4'b0100), 1);
      check("bp_in_ready_full", in_ready, 0);
      drive(mk(32'h33, 32'hC3, 5'd3, 4'b0100));
      in_valid = 1'b1;
      cycle(); cycle();
      check("bp_in_ready_held", in_ready, 0);
      check("bp_head_is_a", {out_valid, alu_result_mem}, {1'b1, 32'h11});
      out_ready = 1'b1;
      send(mk(32'h33, 32'hC3, 5'd3, 4'b0100), 1);
      wait_empty("bp_drain_abc");
      cycle();
      check("bp_empty_after", out_valid, 0);

      // Flush with two held entries
      out_ready = 1'b0;
      send(mk(32'h55, 32'h5, 5'd4, 4'b0010), 1);
      send(mk(32'h66, 32'h6, 5'd6, 4'b0010), 1);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      exp_q.delete();
      check("fl_out_valid", out_valid, 0);
      check("fl_memwrite", memwrite_mem, 0);
      check("fl_in_ready", in_ready, 1);

      // Flush together with an incoming D: D is swallowed
      drive(mk(32'h44, 32'h4, 5'd8, 4'b0100));
      in_valid = 1'b1; flush = 1'b1;
      cycle();
      in_valid = 1'b0; flush = 1'b0;
      check("fl_d_gone", out_valid, 0);
      out_ready = 1'b1;
      cycle();
      check("fl_d_still_gone", {out_valid, fwd_en}, 0);

      // Flush coinciding with an output transfer: G still reaches MEM
      out_ready = 1'b0;
      send(mk(32'h77, 32'h7, 5'd9, 4'b0100), 1);
      out_ready = 1'b1; flush = 1'b1;
      cycle();
      flush = 1'b0; out_ready = 1'b0;
      check("fl_out_xfer_seen", exp_q.size(), 0);
      exp_q.delete();
      check("fl_out_xfer_empty", out_valid, 0);

      // Forwarding gating
      send(mk(32'hAA, 32'h0, 5'd7, 4'b1101), 1);
      check("fwd_load", {fwd_en, memread_mem}, {1'b0, 1'b1});
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      send(mk(32'hBB, 32'h0, 5'd0, 4'b0100), 1);
      check("fwd_x0", {fwd_en, regwrite_mem}, {1'b0, 1'b1});
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      send(mk(32'hCC, 32'h0, 5'd3, 4'b0100), 1);
      check("fwd_rd3", {fwd_en, fwd_rd, fwd_data}, {1'b1, 5'd3, 32'hCC});
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      wait_empty("fwd_drain");

      // Mid-stream reset with two held entries
      send(mk(32'h81, 32'h1, 5'd10, 4'b0110), 1);
      send(mk(32'h82, 32'h2, 5'd11, 4'b0110), 1);
      rst = 1'b1;
      cycle();
      exp_q.delete();
      check("mr_outputs", {out_valid, memtoreg_mem, regwrite_mem, memwrite_mem, memread_mem,
                           alu_result_mem, mem_wdata_mem, rd_addr_mem, fwd_en}, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      send(mk(32'h90, 32'h9, 5'd12, 4'b0100), 1);
      check("mr_next_latency", {out_valid, alu_result_mem}, {1'b1, 32'h90});
      wait_empty("mr_drain");

      // SKID=0: combinational in_ready and replace-on-edge
      s0_regwrite_ex = 1'b1; s0_rd_addr_ex = 5'd2; s0_alu_result_ex = 32'h100;
      s0_in_valid = 1'b1; s0_out_ready = 1'b0;
      cycle();
      check("s0_first", {s0_out_valid, s0_alu_result_mem}, {1'b1, 32'h100});
      s0_alu_result_ex = 32'h200; s0_rd_addr_ex = 5'd6;
      #1;
      check("s0_full_not_ready", s0_in_ready, 0);
      s0_out_ready = 1'b1;
      #1;
      check("s0_ready_comb", s0_in_ready, 1);
      cycle();
      check("s0_replaced", {s0_out_valid, s0_alu_result_mem, s0_rd_addr_mem}, {1'b1, 32'h200, 5'd6});
      s0_in_valid = 1'b0;
      cycle();
      check("s0_drained", {s0_out_valid, s0_regwrite_mem, s0_fwd_en}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
